// File: rtl/clk_mon_pkg.sv
// clk_mon_pkg
//   Shared definitions for the clock period monitor: the measurement FSM
//   state type and the bit positions of the sticky fault flags.
package clk_mon_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } mon_state_t;

  localparam int FLT_RANGE = 0;
  localparam int FLT_STUCK = 1;

endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det
//   Brings an asynchronous level into the CLK domain through two flops and
//   keeps one extra history flop so single-cycle edge strobes can be formed.
// Ports:
//   CLK    in  sampling clock
//   RST_N  in  asynchronous active-low reset
//   din    in  asynchronous input level
//   rise   out one-cycle strobe, synchronized level went 0 -> 1
//   fall   out one-cycle strobe, synchronized level went 1 -> 0
//   level  out synchronized level
module sync_edge_det (
  input  logic CLK,
  input  logic RST_N,
  input  logic din,
  output logic rise,
  output logic fall,
  output logic level
);

  logic s1;
  logic s2;
  logic s3;

  // s1/s2 form the metastability chain; s3 is the previous value of s2.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise  = s2 & ~s3;
  assign fall  = ~s2 & s3;
  assign level = s2;

endmodule

// File: rtl/clk_period_monitor.sv
// clk_period_monitor
//   Measures the high and low phase lengths of a free-running square wave
//   (SIG_IN) in CLK cycles, publishes each complete period with a VALID
//   strobe, range-checks it, raises sticky range/stuck faults and reports
//   LOCKED after LOCK_N consecutive in-range periods.
// Ports:
//   CLK        in  sampling clock
//   RST_N      in  asynchronous active-low reset
//   SIG_IN     in  monitored waveform (asynchronous)
//   CLR_FAULT  in  clears both sticky fault bits
//   HI_CNT     out last high-phase length
//   LO_CNT     out last low-phase length
//   VALID      out one-cycle strobe when HI_CNT/LO_CNT update
//   FAULT      out sticky flags, bit0 range, bit1 stuck
//   LOCKED     out stable-period indicator
//   PER_CNT    out HI_CNT + LO_CNT (only with CLK_PERIOD_MON_TOTAL_EN)
// Build option:
//   CLK_PERIOD_MON_TOTAL_EN adds the PER_CNT output and its adder.
module clk_period_monitor
  import clk_mon_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter int MIN_HI = 2,
  parameter int MAX_HI = 1000,
  parameter int MIN_LO = 2,
  parameter int MAX_LO = 1000,
  parameter int LOCK_N = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             SIG_IN,
  input  logic             CLR_FAULT,
  output logic [CNT_W-1:0] HI_CNT,
  output logic [CNT_W-1:0] LO_CNT,
  output logic             VALID,
  output logic [1:0]       FAULT,
  output logic             LOCKED
`ifdef CLK_PERIOD_MON_TOTAL_EN
  ,
  output logic [CNT_W:0]   PER_CNT
`endif
);

  localparam int LW = $clog2(LOCK_N + 1);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_PRE  = {{(CNT_W-1){1'b1}}, 1'b0};
  localparam logic [CNT_W-1:0] MIN_HI_C = CNT_W'(MIN_HI);
  localparam logic [CNT_W-1:0] MAX_HI_C = CNT_W'(MAX_HI);
  localparam logic [CNT_W-1:0] MIN_LO_C = CNT_W'(MIN_LO);
  localparam logic [CNT_W-1:0] MAX_LO_C = CNT_W'(MAX_LO);
  localparam logic [LW-1:0]    LOCK_C   = LW'(LOCK_N);

  logic             rise;
  logic             fall;
  logic             sync_level_unused;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hi_tmp;
  logic [LW-1:0]    lock_cnt;
  logic [LW-1:0]    lock_nxt;
  logic [1:0]       fault_nxt;
  mon_state_t       state;
  logic             sat_hit;
  logic             period_end;
  logic             in_range;
  logic             range_evt;

  // The FSM works purely from edge strobes; the synchronized level itself
  // is not needed here.
  sync_edge_det u_sync (
    .CLK   (CLK),
    .RST_N (RST_N),
    .din   (SIG_IN),
    .rise  (rise),
    .fall  (fall),
    .level (sync_level_unused)
  );

  // Phase counter: restarts at 1 on every edge so a phase of N cycles
  // reads N in the cycle its closing edge is seen; saturates at all-ones.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt <= CNT_W'(1);
    end else if (rise | fall) begin
      cnt <= CNT_W'(1);
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Stuck is the single event of the counter stepping into saturation, so
  // the edge that finally ends a stuck phase is still seen by IDLE.
  always_comb begin
    sat_hit    = !(rise | fall) && (cnt == CNT_PRE);
    period_end = (state == LOW) && rise;
    in_range   = (hi_tmp >= MIN_HI_C) && (hi_tmp <= MAX_HI_C) &&
                 (cnt >= MIN_LO_C) && (cnt <= MAX_LO_C);
    range_evt  = period_end && !in_range;

    fault_nxt = CLR_FAULT ? 2'b00 : FAULT;
    if (range_evt) fault_nxt[FLT_RANGE] = 1'b1;
    if (sat_hit)   fault_nxt[FLT_STUCK] = 1'b1;

    lock_nxt = lock_cnt;
    if (range_evt || sat_hit) begin
      lock_nxt = '0;
    end else if (period_end && lock_cnt != LOCK_C) begin
      lock_nxt = lock_cnt + LW'(1);
    end
  end

  // Measurement FSM with registered outputs. IDLE waits for a fall so any
  // partial high phase at reset release (or after a stuck event) is dropped.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      hi_tmp   <= '0;
      HI_CNT   <= '0;
      LO_CNT   <= '0;
      VALID    <= 1'b0;
      FAULT    <= 2'b00;
      lock_cnt <= '0;
      LOCKED   <= 1'b0;
    end else begin
      VALID    <= 1'b0;
      FAULT    <= fault_nxt;
      lock_cnt <= lock_nxt;
      LOCKED   <= (lock_nxt == LOCK_C);
      if (sat_hit) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: if (fall) state <= ARM;
          ARM:  if (rise) state <= HIGH;
          HIGH: begin
            if (fall) begin
              state  <= LOW;
              hi_tmp <= cnt;
            end
          end
          LOW: begin
            if (rise) begin
              state  <= HIGH;
              HI_CNT <= hi_tmp;
              LO_CNT <= cnt;
              VALID  <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef CLK_PERIOD_MON_TOTAL_EN
  // Period total, updated alongside HI_CNT/LO_CNT.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      PER_CNT <= '0;
    end else if (period_end && !sat_hit) begin
      PER_CNT <= {1'b0, hi_tmp} + {1'b0, cnt};
    end
  end
`endif

endmodule
